mac_link_bringup_fsm: RTL
=========================

Name: mac_link_bringup_fsm

Overview:
Parametrised successor to the single-lane MAC bring-up controller. It sequences a settle wait, a PCS/MAC reset pulse, and per-stage lock/sync/align checks across NUM_LANES lanes, then enables the packet path. Unlike the one-shot predecessor, it keeps monitoring the link after bring-up, retries automatically on failure up to MAX_RETRY times, and reports the per-lane lock snapshot from the failing stage. It sits in the dclk domain between the MAC stat outputs (already CDC-synchronised) and the user packet logic.

Parameters:
NUM_LANES, 4, number of PCS lanes monitored (1..32)
CLK_PER_US, 75, dclk cycles per microsecond used for every timer load
SETTLE_US, 10000, initial settle wait after reset/restart
RESET_CYCLES, 3, width of the link_reset pulse in dclk cycles
PROP_US, 5, wait after link_reset deasserts
LOCK_TIMEOUT_US, 20000, shared timeout for the lock→sync→align stages
STABLE_US, 1000, time the link must stay aligned before pktgen_enable
MAX_RETRY, 3, automatic re-bring-up attempts before sticky failure
TIMER_W, 32, countdown timer width

Ports:
dclk  in  1  clock
sys_reset  in  1  asynchronous active-high reset
restart  in  1  synchronous pulse; restarts from SETTLE and clears retry count
stat_rx_block_lock  in  NUM_LANES  per-lane block lock
stat_rx_synced  in  NUM_LANES  per-lane lane sync
stat_rx_aligned  in  1  lane alignment
stat_rx_status  in  1  link status
link_reset  out  1  reset pulse to the MAC/PCS
pktgen_enable  out  1  packet path may transmit
link_up  out  1  state is RUN
completion_status  out  5  status code
retry_count  out  $clog2(MAX_RETRY+1)  attempts used
fail_lane_mask  out  NUM_LANES  stat_rx_block_lock & stat_rx_synced, captured when a failure is detected

Behaviour:
- Reset values: link_reset=0, pktgen_enable=0, link_up=0, completion_status=5'h1F (NO_START), retry_count=0, fail_lane_mask=0, timer=0, state=IDLE.
- Status codes: 0 TEST_START, 1 RUNNING, 2 NO_BLOCK_LOCK, 3 PARTIAL_BLOCK_LOCK, 4 INCONSISTENT_BLOCK_LOCK, 5 NO_LANE_SYNC, 6 PARTIAL_LANE_SYNC, 7 INCONSISTENT_LANE_SYNC, 8 NO_ALIGN_OR_STATUS, 9 LOSS_OF_STATUS, 16 RETRY_EXHAUSTED.
- Timer: one TIMER_W down-counter. Each cycle it decrements if nonzero. A load wins over the decrement. Load values are us*CLK_PER_US, truncated to TIMER_W. A state "times out" when the timer reads 0.
- IDLE → SETTLE next cycle. On entry to SETTLE, load SETTLE_US and set status=TEST_START.
- SETTLE: wait for timeout → RST. On entry to RST, set link_reset=1 and load RESET_CYCLES.
- RST: on timeout, clear link_reset, load PROP_US → PROP. The link_reset pulse is exactly RESET_CYCLES+1 cycles long.
- PROP: on timeout, load LOCK_TIMEOUT_US → ANY_LOCK.
- ANY_LOCK: |lock → ALL_LOCK. On timeout, fail with NO_BLOCK_LOCK.
- ALL_LOCK: &lock → ANY_SYNC. On timeout, fail with PARTIAL_BLOCK_LOCK.
- ANY_SYNC, ALL_SYNC, ALIGN: first check ~&lock → INCONSISTENT_BLOCK_LOCK. In ALIGN, also check ~&synced → INCONSISTENT_LANE_SYNC. Otherwise advance on |synced, &synced, and (aligned&&status) respectively. Timeout codes are 5, 6 and 8 respectively. The timer is not reloaded between stages.
- On entry to STABLE, load STABLE_US. Any loss of &lock, &synced, aligned or status fails with LOSS_OF_STATUS. On timeout go to RUN.
- On entry to RUN: pktgen_enable=1, link_up=1, status=RUNNING, retry_count=0. RUN has no timeout. Any loss as in STABLE fails with LOSS_OF_STATUS, and pktgen_enable/link_up drop in the same cycle as the state change.
- FAIL (one cycle): capture fail_lane_mask and drop pktgen_enable/link_up.
  - If retry_count<MAX_RETRY: increment retry_count, go to RST (settle is skipped), keep the failure code visible until RUN.
  - Otherwise go to DEAD with status=RETRY_EXHAUSTED. The last failure code is preserved in fail_lane_mask context only.
- DEAD: sticky until restart or sys_reset.
- Precedence: sys_reset > restart > stage evaluation. When a check and a timeout occur in the same cycle, the check wins (the timer reads nonzero that cycle).
- restart from any state: link_reset=0, pktgen_enable=0, link_up=0, retry_count=0, fail_lane_mask unchanged, then go to SETTLE with a reload.
- sys_reset mid-pulse drops link_reset asynchronously.
- With NUM_LANES=1, ANY and ALL stages pass in consecutive cycles.

Test Plan:
- Bench parameters for all scenarios: CLK_PER_US=1, SETTLE_US=10, PROP_US=2, LOCK_TIMEOUT_US=50, STABLE_US=5, MAX_RETRY=2, NUM_LANES=4.
- All inputs high after link_reset → link_reset high 4 cycles; link_up=1, pktgen_enable=1, status=1, retry_count=0 after settle+reset+prop+stages+5.
- Lock stuck at 4'b0111 → PARTIAL_BLOCK_LOCK (3); fail_lane_mask=4'b0111; two retries (retry_count 1, then 2, link_reset re-pulses); then status=16 held until restart.
- Link up, then deassert stat_rx_status for 1 cycle in RUN → pktgen_enable=0 in the same cycle as the FAIL transition; status=9; retry_count=1; recovers to RUN with retry_count=0.
- Lock drops on lane 2 during ALIGN → status=4 (INCONSISTENT_BLOCK_LOCK), not 8.
- restart pulse in DEAD → status=0, retry_count=0, SETTLE timer reloaded to 10; sys_reset asserted during RST → link_reset=0 immediately and status=5'h1F.

Source files
------------

// File: rtl/mac_link_bringup_fsm.sv
// Multi-lane MAC/PCS bring-up sequencer: settle, reset pulse, staged lock/sync/align
// checks, stability window, then continuous link monitoring with bounded automatic retry.
module mac_link_bringup_fsm #(
  parameter int NUM_LANES       = 4,
  parameter int CLK_PER_US      = 75,
  parameter int SETTLE_US       = 10000,
  parameter int RESET_CYCLES    = 3,
  parameter int PROP_US         = 5,
  parameter int LOCK_TIMEOUT_US = 20000,
  parameter int STABLE_US       = 1000,
  parameter int MAX_RETRY       = 3,
  parameter int TIMER_W         = 32
) (
  input  logic                           dclk,
  input  logic                           sys_reset,
  input  logic                           restart,
  input  logic [NUM_LANES-1:0]           stat_rx_block_lock,
  input  logic [NUM_LANES-1:0]           stat_rx_synced,
  input  logic                           stat_rx_aligned,
  input  logic                           stat_rx_status,
  output logic                           link_reset,
  output logic                           pktgen_enable,
  output logic                           link_up,
  output logic [4:0]                     completion_status,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_count,
  output logic [NUM_LANES-1:0]           fail_lane_mask
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(longint'(SETTLE_US) * longint'(CLK_PER_US));
  localparam logic [TIMER_W-1:0] RESET_LD  = TIMER_W'(RESET_CYCLES);
  localparam logic [TIMER_W-1:0] PROP_LD   = TIMER_W'(longint'(PROP_US) * longint'(CLK_PER_US));
  localparam logic [TIMER_W-1:0] LOCK_LD   = TIMER_W'(longint'(LOCK_TIMEOUT_US) * longint'(CLK_PER_US));
  localparam logic [TIMER_W-1:0] STABLE_LD = TIMER_W'(longint'(STABLE_US) * longint'(CLK_PER_US));

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_RST, S_PROP, S_ANY_LOCK, S_ALL_LOCK, S_ANY_SYNC,
    S_ALL_SYNC, S_ALIGN, S_STABLE, S_RUN, S_FAIL, S_DEAD
  } state_e;

  typedef enum logic [4:0] {
    ST_TEST_START         = 5'd0,
    ST_RUNNING            = 5'd1,
    ST_NO_BLOCK_LOCK      = 5'd2,
    ST_PARTIAL_BLOCK_LOCK = 5'd3,
    ST_INCONS_BLOCK_LOCK  = 5'd4,
    ST_NO_LANE_SYNC       = 5'd5,
    ST_PARTIAL_LANE_SYNC  = 5'd6,
    ST_INCONS_LANE_SYNC   = 5'd7,
    ST_NO_ALIGN_OR_STATUS = 5'd8,
    ST_LOSS_OF_STATUS     = 5'd9,
    ST_RETRY_EXHAUSTED    = 5'd16,
    ST_NO_START           = 5'h1F
  } status_e;

  state_e               state, state_d;
  status_e              status_q, status_d, fail_code;
  logic [TIMER_W-1:0]   timer, timer_d, load_val;
  logic                 load, fail, timeout;
  logic                 link_reset_d, pktgen_d;
  logic [RETRY_W-1:0]   retry_d;
  logic [NUM_LANES-1:0] mask_d;
  logic                 any_lock, all_lock, any_sync, all_sync, healthy;

  assign any_lock = |stat_rx_block_lock;
  assign all_lock = &stat_rx_block_lock;
  assign any_sync = |stat_rx_synced;
  assign all_sync = &stat_rx_synced;
  assign healthy  = all_lock && all_sync && stat_rx_aligned && stat_rx_status;
  assign timeout  = (timer == '0);

  assign link_up           = (state == S_RUN);
  assign completion_status = status_q;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state;
    status_d     = status_q;
    link_reset_d = link_reset;
    pktgen_d     = pktgen_enable;
    retry_d      = retry_count;
    mask_d       = fail_lane_mask;
    load         = 1'b0;
    load_val     = '0;
    fail         = 1'b0;
    fail_code    = ST_LOSS_OF_STATUS;

    if (restart) begin
      state_d      = S_SETTLE;
      load         = 1'b1;
      load_val     = SETTLE_LD;
      status_d     = ST_TEST_START;
      link_reset_d = 1'b0;
      pktgen_d     = 1'b0;
      retry_d      = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_d  = S_SETTLE;
          load     = 1'b1;
          load_val = SETTLE_LD;
          status_d = ST_TEST_START;
        end
        S_SETTLE: if (timeout) begin
          state_d      = S_RST;
          load         = 1'b1;
          load_val     = RESET_LD;
          link_reset_d = 1'b1;
        end
        S_RST: if (timeout) begin
          state_d      = S_PROP;
          load         = 1'b1;
          load_val     = PROP_LD;
          link_reset_d = 1'b0;
        end
        S_PROP: if (timeout) begin
          state_d  = S_ANY_LOCK;
          load     = 1'b1;
          load_val = LOCK_LD;
        end
        // Lock/sync/align stages share one timeout budget loaded on entry to ANY_LOCK.
        S_ANY_LOCK: begin
          if (any_lock)     state_d = S_ALL_LOCK;
          else if (timeout) begin fail = 1'b1; fail_code = ST_NO_BLOCK_LOCK; end
        end
        S_ALL_LOCK: begin
          if (all_lock)     state_d = S_ANY_SYNC;
          else if (timeout) begin fail = 1'b1; fail_code = ST_PARTIAL_BLOCK_LOCK; end
        end
        S_ANY_SYNC: begin
          if (!all_lock)    begin fail = 1'b1; fail_code = ST_INCONS_BLOCK_LOCK; end
          else if (any_sync) state_d = S_ALL_SYNC;
          else if (timeout) begin fail = 1'b1; fail_code = ST_NO_LANE_SYNC; end
        end
        S_ALL_SYNC: begin
          if (!all_lock)    begin fail = 1'b1; fail_code = ST_INCONS_BLOCK_LOCK; end
          else if (all_sync) state_d = S_ALIGN;
          else if (timeout) begin fail = 1'b1; fail_code = ST_PARTIAL_LANE_SYNC; end
        end
        S_ALIGN: begin
          if (!all_lock)      begin fail = 1'b1; fail_code = ST_INCONS_BLOCK_LOCK; end
          else if (!all_sync) begin fail = 1'b1; fail_code = ST_INCONS_LANE_SYNC; end
          else if (stat_rx_aligned && stat_rx_status) begin
            state_d  = S_STABLE;
            load     = 1'b1;
            load_val = STABLE_LD;
          end else if (timeout) begin fail = 1'b1; fail_code = ST_NO_ALIGN_OR_STATUS; end
        end
        S_STABLE: begin
          if (!healthy) fail = 1'b1;
          else if (timeout) begin
            state_d  = S_RUN;
            status_d = ST_RUNNING;
            pktgen_d = 1'b1;
            retry_d  = '0;
          end
        end
        S_RUN: if (!healthy) fail = 1'b1;
        S_FAIL: begin
          if (retry_count < RETRY_W'(MAX_RETRY)) begin
            state_d      = S_RST;
            load         = 1'b1;
            load_val     = RESET_LD;
            link_reset_d = 1'b1;
            retry_d      = retry_count + RETRY_W'(1);
          end else begin
            state_d  = S_DEAD;
            status_d = ST_RETRY_EXHAUSTED;
          end
        end
        S_DEAD:  state_d = S_DEAD;
        default: state_d = S_IDLE;
      endcase

      if (fail) begin
        state_d  = S_FAIL;
        status_d = fail_code;
        mask_d   = stat_rx_block_lock & stat_rx_synced;
        pktgen_d = 1'b0;
      end
    end
  end

  // A load takes priority over the free-running decrement; the counter parks at zero.
  always_comb begin
    timer_d = timer;
    if (load)            timer_d = load_val;
    else if (!timeout)   timer_d = timer - TIMER_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge dclk or posedge sys_reset) begin
    if (sys_reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      status_q       <= ST_NO_START;
      link_reset     <= 1'b0;
      pktgen_enable  <= 1'b0;
      retry_count    <= '0;
      fail_lane_mask <= '0;
    end else begin
      state          <= state_d;
      timer          <= timer_d;
      status_q       <= status_d;
      link_reset     <= link_reset_d;
      pktgen_enable  <= pktgen_d;
      retry_count    <= retry_d;
      fail_lane_mask <= mask_d;
    end
  end

endmodule
